// File: rtl/pbp_history_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pbp_history_ctrl_pkg
// Brief    : Shared constants, in-flight/update record types and the GHR
//            shift helper for the perceptron-predictor history manager.
// Revision : 1.0 - initial release
// ============================================================================
package pbp_history_ctrl_pkg;

  // Global history length; must match the pbp GHR_LENGTH.
  localparam int GHR_LENGTH  = 10;
  // Maximum number of unresolved branches (power of two, >= 2).
  localparam int NR_INFLIGHT = 8;
  // Tag width: index bits plus one wrap bit.
  localparam int TAG_W       = $clog2(NR_INFLIGHT) + 1;
  // Virtual address width of branch PCs.
  localparam int VLEN        = 32;

  typedef struct packed {
    logic [VLEN-1:0]       pc;
    logic                  taken;
    logic [GHR_LENGTH-1:0] history;
  } pbp_inflight_t;

  typedef struct packed {
    logic                  valid;
    logic [VLEN-1:0]       pc;
    logic [GHR_LENGTH-1:0] history;
    logic                  taken;
    logic                  mispredict;
  } pbp_update_t;

  // Newest outcome enters at bit 0, oldest falls off the top.
  function automatic logic [GHR_LENGTH-1:0] ghr_shift(
    input logic [GHR_LENGTH-1:0] h,
    input logic                  t
  );
    return {h[GHR_LENGTH-2:0], t};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pbp_history_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pbp_history_ctrl_if
// Brief    : Predict / resolve / training-update bundle between the
//            frontend, execute and the history controller.
// Revision : 1.0 - initial release
// ============================================================================
interface pbp_history_ctrl_if;
  import pbp_history_ctrl_pkg::*;

  // Prediction channel (frontend -> controller)
  logic                  pred_valid_i;
  logic                  pred_ready_o;
  logic [VLEN-1:0]       pred_pc_i;
  logic                  pred_taken_i;
  logic [TAG_W-1:0]      pred_tag_o;

  // Resolution channel (execute -> controller)
  logic                  res_valid_i;
  logic [TAG_W-1:0]      res_tag_i;
  logic                  res_taken_i;
  logic                  res_mispredict_i;

  // Training packet (controller -> pbp)
  logic                  upd_valid_o;
  logic [VLEN-1:0]       upd_pc_o;
  logic [GHR_LENGTH-1:0] upd_history_o;
  logic                  upd_taken_o;
  logic                  upd_mispredict_o;

  // Controller side
  modport slave (
    input  pred_valid_i, pred_pc_i, pred_taken_i,
    output pred_ready_o, pred_tag_o,
    input  res_valid_i, res_tag_i, res_taken_i, res_mispredict_i,
    output upd_valid_o, upd_pc_o, upd_history_o, upd_taken_o, upd_mispredict_o
  );

  // Frontend / execute / pbp side
  modport master (
    output pred_valid_i, pred_pc_i, pred_taken_i,
    input  pred_ready_o, pred_tag_o,
    output res_valid_i, res_tag_i, res_taken_i, res_mispredict_i,
    input  upd_valid_o, upd_pc_o, upd_history_o, upd_taken_o, upd_mispredict_o
  );

endinterface
`default_nettype wire

// File: rtl/pbp_history_ctrl_inflight_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pbp_history_ctrl_inflight_fifo
// Brief    : In-order circular buffer of in-flight predicted branches.
//            Supports push at tail, pop at head, truncate to head+1
//            (mispredict squash) and clear to head (flush).
// Revision : 1.0 - initial release
// ============================================================================
module pbp_history_ctrl_inflight_fifo
  import pbp_history_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  pbp_inflight_t    push_data_i,
  input  logic             pop_i,
  input  logic             trunc_i,
  input  logic             clear_i,
  output pbp_inflight_t    head_data_o,
  output logic [TAG_W-1:0] head_tag_o,
  output logic [TAG_W-1:0] tail_tag_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [TAG_W-1:0] occupancy_o
);

  localparam int               IDX_W   = TAG_W - 1;
  localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  pbp_inflight_t    mem_q [NR_INFLIGHT];

  // Pointer next-state: clear wins over truncate, which wins over push.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (pop_i) begin
      head_d = head_q + TAG_ONE;
    end
    if (clear_i) begin
      tail_d = head_d;
    end else if (trunc_i) begin
      tail_d = head_q + TAG_ONE;
    end else if (push_i) begin
      tail_d = tail_q + TAG_ONE;
    end
  end

  // Head/tail pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Entry storage; contents are only meaningful between head and tail.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[tail_q[IDX_W-1:0]] <= push_data_i;
    end
  end

  assign head_data_o = mem_q[head_q[IDX_W-1:0]];
  assign head_tag_o  = head_q;
  assign tail_tag_o  = tail_q;
  assign empty_o     = (head_q == tail_q);
  assign full_o      = (head_q[TAG_W-1] != tail_q[TAG_W-1]) &&
                       (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]);
  assign occupancy_o = tail_q - head_q;

endmodule
`default_nettype wire

// File: rtl/pbp_history_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pbp_history_ctrl
// Brief    : Global-history manager for the perceptron predictor. Keeps the
//            speculative and committed GHRs, tracks in-flight branches and
//            emits training packets on in-order resolution.
// Revision : 1.0 - initial release
// ============================================================================
module pbp_history_ctrl
  import pbp_history_ctrl_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  debug_mode_i,
  pbp_history_ctrl_if.slave     bus,
  output logic [GHR_LENGTH-1:0] spec_history_o,
  output logic [GHR_LENGTH-1:0] commit_history_o,
  output logic [TAG_W-1:0]      occupancy_o,
  output logic                  err_o
);

  logic [GHR_LENGTH-1:0] spec_q, spec_d;
  logic [GHR_LENGTH-1:0] commit_q, commit_d;
  pbp_update_t           upd_q, upd_d;
  logic                  err_q, err_d;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [TAG_W-1:0]      head_tag;
  logic [TAG_W-1:0]      tail_tag;
  pbp_inflight_t         head_entry;
  pbp_inflight_t         push_entry;
  logic                  accept;
  logic                  legal_res;
  logic                  mispredict;

  // Full is taken from registered pointers: a resolve freeing a slot this
  // cycle does not open the door for a same-cycle prediction. A mispredict
  // in flight also blocks, since it rewrites the tail this cycle.
  assign bus.pred_ready_o = !fifo_full && !flush_i &&
                            !(bus.res_valid_i && bus.res_mispredict_i);
  assign accept           = bus.pred_valid_i && bus.pred_ready_o;
  assign bus.pred_tag_o   = tail_tag;

  // Resolves must arrive in program order: only the head may resolve.
  assign legal_res  = bus.res_valid_i && !fifo_empty && (bus.res_tag_i == head_tag);
  assign mispredict = legal_res && bus.res_mispredict_i;
  assign err_d      = bus.res_valid_i && !legal_res;

  // Snapshot is the pre-shift speculative history the pbp used to predict.
  assign push_entry = '{pc: bus.pred_pc_i, taken: bus.pred_taken_i, history: spec_q};

  pbp_history_ctrl_inflight_fifo u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (accept),
    .push_data_i (push_entry),
    .pop_i       (legal_res),
    .trunc_i     (mispredict),
    .clear_i     (flush_i),
    .head_data_o (head_entry),
    .head_tag_o  (head_tag),
    .tail_tag_o  (tail_tag),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .occupancy_o (occupancy_o)
  );

  // GHR next-state: flush restores from the (post-resolve) committed GHR,
  // a mispredict rebuilds from the snapshot, otherwise predictions shift in.
  always_comb begin
    commit_d = commit_q;
    spec_d   = spec_q;
    if (legal_res) begin
      commit_d = ghr_shift(commit_q, bus.res_taken_i);
    end
    if (flush_i) begin
      spec_d = commit_d;
    end else if (mispredict) begin
      spec_d = ghr_shift(head_entry.history, bus.res_taken_i);
    end else if (accept) begin
      spec_d = ghr_shift(spec_q, bus.pred_taken_i);
    end
  end

  // Training packet next-state: payload latched on every legal resolve,
  // valid suppressed while the core is in debug mode.
  always_comb begin
    upd_d       = upd_q;
    upd_d.valid = 1'b0;
    if (legal_res) begin
      upd_d.valid      = !debug_mode_i;
      upd_d.pc         = head_entry.pc;
      upd_d.history    = head_entry.history;
      upd_d.taken      = bus.res_taken_i;
      upd_d.mispredict = bus.res_mispredict_i;
    end
  end

  // GHR, training packet and error pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      spec_q   <= '0;
      commit_q <= '0;
      upd_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      spec_q   <= spec_d;
      commit_q <= commit_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
    end
  end

  assign spec_history_o       = spec_q;
  assign commit_history_o     = commit_q;
  assign err_o                = err_q;
  assign bus.upd_valid_o      = upd_q.valid;
  assign bus.upd_pc_o         = upd_q.pc;
  assign bus.upd_history_o    = upd_q.history;
  assign bus.upd_taken_o      = upd_q.taken;
  assign bus.upd_mispredict_o = upd_q.mispredict;

endmodule
`default_nettype wire

// File: tb/tb_pbp_history_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pbp_history_ctrl
// Brief    : Directed self-checking bench for pbp_history_ctrl with an
//            in-flight scoreboard and a queue of expected training packets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pbp_history_ctrl;
  import pbp_history_ctrl_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic                  dbg;
  logic [GHR_LENGTH-1:0] spec_h;
  logic [GHR_LENGTH-1:0] commit_h;
  logic [TAG_W-1:0]      occ;
  logic                  err;

  pbp_history_ctrl_if bus();

  pbp_history_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush),
    .debug_mode_i     (dbg),
    .bus              (bus),
    .spec_history_o   (spec_h),
    .commit_history_o (commit_h),
    .occupancy_o      (occ),
    .err_o            (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0]      tag;
    logic [VLEN-1:0]       pc;
    logic                  taken;
    logic [GHR_LENGTH-1:0] hist;
  } sb_t;

  typedef struct {
    logic [VLEN-1:0]       pc;
    logic [GHR_LENGTH-1:0] hist;
    logic                  taken;
    logic                  mis;
  } exp_upd_t;

  sb_t                   sb[$];
  exp_upd_t              upd_exp[$];
  logic [TAG_W-1:0]      tail_m;
  logic [TAG_W-1:0]      head_m;
  logic [GHR_LENGTH-1:0] spec_m;
  logic [GHR_LENGTH-1:0] commit_m;
  int                    errors = 0;
  int                    checks = 0;

  function automatic logic [GHR_LENGTH-1:0] shl(input logic [GHR_LENGTH-1:0] h, input logic t);
    return {h[GHR_LENGTH-2:0], t};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    flush                = 1'b0;
    dbg                  = 1'b0;
    bus.pred_valid_i     = 1'b0;
    bus.pred_pc_i        = '0;
    bus.pred_taken_i     = 1'b0;
    bus.res_valid_i      = 1'b0;
    bus.res_tag_i        = '0;
    bus.res_taken_i      = 1'b0;
    bus.res_mispredict_i = 1'b0;
  endtask

  // Advance one clock and score any training packet that appeared.
  task automatic tick();
    exp_upd_t e;
    @(posedge clk);
    #1;
    if (bus.upd_valid_o === 1'b1) begin
      if (upd_exp.size() > 0) begin
        e = upd_exp.pop_front();
        chk("upd_pc", bus.upd_pc_o, e.pc);
        chk("upd_history", bus.upd_history_o, e.hist);
        chk("upd_taken", bus.upd_taken_o, e.taken);
        chk("upd_mispredict", bus.upd_mispredict_o, e.mis);
      end else begin
        chk("upd_unexpected", bus.upd_valid_o, 1'b0);
      end
    end else if (upd_exp.size() > 0) begin
      void'(upd_exp.pop_front());
      chk("upd_missing", bus.upd_valid_o, 1'b1);
    end
  endtask

  // One directed cycle: drive everything at the falling edge, update the
  // model, clock, then compare registered state.
  task automatic step(input logic rv, input logic [TAG_W-1:0] rtag, input logic rtaken,
                      input logic rmis, input logic pv, input logic [VLEN-1:0] ppc,
                      input logic ptaken, input logic fl, input logic dg, input string name);
    logic legal;
    logic exp_ready;
    sb_t  e;
    @(negedge clk);
    bus.res_valid_i      = rv;
    bus.res_tag_i        = rtag;
    bus.res_taken_i      = rtaken;
    bus.res_mispredict_i = rmis;
    bus.pred_valid_i     = pv;
    bus.pred_pc_i        = ppc;
    bus.pred_taken_i     = ptaken;
    flush                = fl;
    dbg                  = dg;
    #1;
    exp_ready = (sb.size() != NR_INFLIGHT) && !fl && !(rv && rmis);
    chk({name, "_ready"}, bus.pred_ready_o, exp_ready);
    legal = rv && (sb.size() > 0) && (sb[0].tag == rtag);
    if (pv && exp_ready) begin
      chk({name, "_tag"}, bus.pred_tag_o, tail_m);
      sb.push_back('{tail_m, ppc, ptaken, spec_m});
      spec_m = shl(spec_m, ptaken);
      tail_m++;
    end
    if (legal) begin
      e = sb.pop_front();
      head_m++;
      commit_m = shl(commit_m, rtaken);
      if (!dg) upd_exp.push_back('{e.pc, e.hist, rtaken, rmis});
      if (rmis) begin
        spec_m = shl(e.hist, rtaken);
        sb.delete();
        tail_m = head_m;
      end
    end
    if (fl) begin
      sb.delete();
      tail_m = head_m;
      spec_m = commit_m;
    end
    tick();
    clear_inputs();
    chk({name, "_err"}, err, rv && !legal);
    chk({name, "_spec"}, spec_h, spec_m);
    chk({name, "_commit"}, commit_h, commit_m);
    chk({name, "_occ"}, occ, sb.size());
  endtask

  task automatic pred(input logic [VLEN-1:0] pc, input logic t, input string name);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, pc, t, 1'b0, 1'b0, name);
  endtask

  task automatic res(input logic [TAG_W-1:0] tag, input logic t, input logic mis, input string name);
    step(1'b1, tag, t, mis, 1'b0, '0, 1'b0, 1'b0, 1'b0, name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    sb.delete();
    upd_exp.delete();
    tail_m   = '0;
    head_m   = '0;
    spec_m   = '0;
    commit_m = '0;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_spec", spec_h, '0);
    chk("rst_commit", commit_h, '0);
    chk("rst_occ", occ, '0);
    chk("rst_upd_valid", bus.upd_valid_o, 1'b0);
    chk("rst_upd_pc", bus.upd_pc_o, '0);
    chk("rst_err", err, 1'b0);
    chk("rst_ready", bus.pred_ready_o, 1'b1);
    chk("rst_tag", bus.pred_tag_o, '0);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    do_reset();

    // Case 1: three accepted predictions T,N,T
    pred(32'h100, 1'b1, "c1_br0");
    pred(32'h104, 1'b0, "c1_br1");
    pred(32'h108, 1'b1, "c1_br2");
    chk("c1_spec_101", spec_h, 10'b0000000101);
    chk("c1_occ_3", occ, 4'd3);

    // Case 2: correct resolve of tag 0
    res(4'd0, 1'b1, 1'b0, "c2_res0");
    chk("c2_commit_1", commit_h, 10'b0000000001);
    chk("c2_spec_101", spec_h, 10'b0000000101);

    // Case 3: mispredict on tag 1 with a same-cycle prediction refused
    step(1'b1, 4'd1, 1'b1, 1'b1, 1'b1, 32'h10C, 1'b0, 1'b0, 1'b0, "c3_mis");
    chk("c3_spec_11", spec_h, 10'b0000000011);
    chk("c3_commit_11", commit_h, 10'b0000000011);
    chk("c3_occ_0", occ, 4'd0);

    // Case 5: resolve on empty FIFO, then a resolve with the wrong tag
    res(4'd2, 1'b0, 1'b0, "c5_empty");
    pred(32'h200, 1'b1, "c5_br");
    res(sb[0].tag + 4'd1, 1'b1, 1'b0, "c5_badtag");
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, "c5_idle");

    // Case 6: debug-mode resolve trains nothing but still commits
    step(1'b1, sb[0].tag, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, "c6_dbg");
    for (int i = 0; i < 4; i++) begin
      pred(32'h240 + 32'(4 * i), i[0], "c6_fill");
    end
    // Flush with a same-cycle legal resolve of the head
    step(1'b1, sb[0].tag, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, "c6_flush");
    chk("c6_occ_0", occ, 4'd0);

    // Reset with entries outstanding
    pred(32'h280, 1'b1, "rs_br0");
    pred(32'h284, 1'b1, "rs_br1");
    do_reset();

    // Case 4: fill, refuse when full, refuse beside a freeing resolve, wrap
    for (int i = 0; i < NR_INFLIGHT; i++) begin
      pred(32'h300 + 32'(4 * i), i[0], "c4_fill");
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h3F0, 1'b1, 1'b0, 1'b0, "c4_full");
    step(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 32'h400, 1'b1, 1'b0, 1'b0, "c4_res_pred");
    pred(32'h400, 1'b1, "c4_wrap");
    chk("c4_tail_wrapped", bus.pred_tag_o, 4'd9);
    // Drain in order, with one mispredict late in the run
    while (sb.size() > 2) begin
      res(sb[0].tag, sb[0].taken, 1'b0, "c4_drain");
    end
    res(sb[0].tag, !sb[0].taken, 1'b1, "c4_mis");
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, "c4_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
